// File: rtl/bk_add_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// bk_add_accumulator_pkg: word type and constants shared by the adder family.
// Revision: 1.0
// ============================================================================
package bk_add_accumulator_pkg;

    localparam int ADD_WIDTH = 32;

    typedef logic [ADD_WIDTH-1:0] word_t;

    localparam word_t ALL_ONES = '1;

endpackage
`default_nettype wire

// File: rtl/bk_add_accumulator_bkadder.sv
`default_nettype none
// ============================================================================
// BKadderwithcarryselect: 32-bit adder, Brent-Kung 16-bit halves with carry-select upper half.
// Revision: 1.0
// ============================================================================
module BKadderwithcarryselect
    import bk_add_accumulator_pkg::*;
(
    input  word_t a,
    input  word_t b,
    output word_t sum,
    output logic  cout
);

    localparam int HALF = ADD_WIDTH / 2;

    // Returns {carry_out, sum} of a HALF-bit Brent-Kung prefix add.
    function automatic logic [HALF:0] bk_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
        logic [HALF-1:0] g;
        logic [HALF-1:0] p;
        logic [HALF-1:0] pp;
        logic [HALF:0]   r;
        pp   = x ^ y;
        p    = pp;
        g    = x & y;
        g[0] = g[0] | (pp[0] & cin);
        for (int d = 1; d < HALF; d = d * 2) begin
            for (int i = 2 * d - 1; i < HALF; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        for (int d = HALF / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < HALF; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        r[0] = pp[0] ^ cin;
        for (int i = 1; i < HALF; i++) begin
            r[i] = pp[i] ^ g[i-1];
        end
        r[HALF] = g[HALF-1];
        return r;
    endfunction

    logic [HALF:0] lo;
    logic [HALF:0] hi0;
    logic [HALF:0] hi1;

    assign lo  = bk_add(a[HALF-1:0],         b[HALF-1:0],         1'b0);
    assign hi0 = bk_add(a[ADD_WIDTH-1:HALF], b[ADD_WIDTH-1:HALF], 1'b0);
    assign hi1 = bk_add(a[ADD_WIDTH-1:HALF], b[ADD_WIDTH-1:HALF], 1'b1);

    assign sum  = {(lo[HALF] ? hi1[HALF-1:0] : hi0[HALF-1:0]), lo[HALF-1:0]};
    assign cout = lo[HALF] ? hi1[HALF] : hi0[HALF];

endmodule
`default_nettype wire

// File: rtl/bk_add_accumulator.sv
`default_nettype none
// ============================================================================
// bk_add_accumulator: streaming running-sum around the Brent-Kung adder.
// Revision: 1.0
// ============================================================================
module bk_add_accumulator
    import bk_add_accumulator_pkg::*;
#(
    parameter int WIDTH    = ADD_WIDTH,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_carry,
    output logic             carry_sticky,
    output logic [CNT_W-1:0] op_count
);

    logic             in_fire;
    logic             out_fire;
    word_t            add_a;
    word_t            add_sum;
    logic             add_cout;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    // Single output register with no skid: accept only when it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign add_a    = in_clear ? '0 : acc_out;
    assign cnt_base = in_clear ? '0 : op_count;
    assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

    BKadderwithcarryselect u_adder (
        .a    (add_a),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out      <= '0;
            out_valid    <= 1'b0;
            out_carry    <= 1'b0;
            carry_sticky <= 1'b0;
            op_count     <= '0;
        end else if (in_fire) begin
            acc_out      <= (SATURATE != 0 && add_cout) ? ALL_ONES : add_sum;
            out_carry    <= add_cout;
            out_valid    <= 1'b1;
            carry_sticky <= (in_clear ? 1'b0 : carry_sticky) | add_cout;
            op_count     <= cnt_next;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bk_add_accumulator.sv
`default_nettype none
// ============================================================================
// tb_bk_add_accumulator: directed checks of wrap and saturating accumulators.
// Revision: 1.0
// ============================================================================
module tb_bk_add_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_clear = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] acc_out   [2];
    logic        out_carry [2];
    logic        sticky    [2];
    logic [7:0]  op_count  [2];

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model state: index 0 wraps, index 1 saturates.
    logic [31:0] m_acc   [2];
    logic        m_valid [2];
    logic        m_carry [2];
    logic        m_sticky[2];
    int          m_cnt   [2];

    always #5 clk = ~clk;

    bk_add_accumulator #(.WIDTH(32), .SATURATE(0), .CNT_W(8)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_clear(in_clear), .out_valid(out_valid[0]),
        .out_ready(out_ready), .acc_out(acc_out[0]), .out_carry(out_carry[0]),
        .carry_sticky(sticky[0]), .op_count(op_count[0])
    );

    bk_add_accumulator #(.WIDTH(32), .SATURATE(1), .CNT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_clear(in_clear), .out_valid(out_valid[1]),
        .out_ready(out_ready), .acc_out(acc_out[1]), .out_carry(out_carry[1]),
        .carry_sticky(sticky[1]), .op_count(op_count[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_acc[s] = '0; m_valid[s] = 1'b0; m_carry[s] = 1'b0;
                m_sticky[s] = 1'b0; m_cnt[s] = 0;
            end else if (in_valid && (!m_valid[s] || out_ready)) begin
                longint unsigned total;
                total = (in_clear ? 64'd0 : {32'd0, m_acc[s]}) + {32'd0, in_data};
                m_carry[s]  = total >= 64'h1_0000_0000;
                m_acc[s]    = (s == 1 && m_carry[s]) ? 32'hFFFF_FFFF : total[31:0];
                m_sticky[s] = (in_clear ? 1'b0 : m_sticky[s]) | m_carry[s];
                m_cnt[s]    = in_clear ? 1 : (m_cnt[s] >= 255 ? 255 : m_cnt[s] + 1);
                m_valid[s]  = 1'b1;
            end else if (m_valid[s] && out_ready) begin
                m_valid[s] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("out_valid[%0d]", s), 32'(out_valid[s]), 32'(m_valid[s]));
                chk($sformatf("in_ready[%0d]", s), 32'(in_ready[s]), 32'(!m_valid[s] || out_ready));
                chk($sformatf("acc_out[%0d]", s), acc_out[s], m_acc[s]);
                chk($sformatf("out_carry[%0d]", s), 32'(out_carry[s]), 32'(m_carry[s]));
                chk($sformatf("carry_sticky[%0d]", s), 32'(sticky[s]), 32'(m_sticky[s]));
                chk($sformatf("op_count[%0d]", s), 32'(op_count[s]), m_cnt[s]);
            end
        end
    end

    // Presents one operand and holds it until the wrapping instance accepts it.
    task automatic send(input logic [31:0] d, input logic c);
        bit taken = 1'b0;
        in_valid = 1'b1; in_data = d; in_clear = c;
        #1;
        for (int k = 0; k < 50 && !taken; k++) begin
            taken = in_ready[0];
            @(posedge clk); #1;
        end
        if (!taken) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; in_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        longint unsigned ref_sum;
        bit ref_sticky;
        logic [31:0] d;

        @(posedge clk); #1;
        do_reset();
        started = 1'b1;
        chk("reset_acc", acc_out[0], 32'h0);
        chk("reset_valid", 32'(out_valid[0]), 32'h0);

        // Simple accumulation
        send(32'h1, 1'b1);
        chk("t1_first", acc_out[0], 32'h1);
        send(32'h1, 1'b0);
        chk("t1_acc", acc_out[0], 32'h2);
        chk("t1_count", 32'(op_count[0]), 32'd2);
        chk("t1_sticky", 32'(sticky[0]), 32'd0);

        // Wrap on carry-out
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h1, 1'b0);
        chk("t2_wrap_acc", acc_out[0], 32'h0);
        chk("t2_wrap_carry", 32'(out_carry[0]), 32'd1);
        chk("t2_sat_acc", acc_out[1], 32'hFFFF_FFFF);
        send(32'h5, 1'b0);
        chk("t2_after_acc", acc_out[0], 32'h5);
        chk("t2_after_carry", 32'(out_carry[0]), 32'd0);
        chk("t2_after_sticky", 32'(sticky[0]), 32'd1);

        // Saturation
        send(32'hFFFF_0006, 1'b1);
        send(32'h1256_0006, 1'b0);
        chk("t3_sat_acc", acc_out[1], 32'hFFFF_FFFF);
        chk("t3_sat_carry", 32'(out_carry[1]), 32'd1);
        chk("t3_sat_sticky", 32'(sticky[1]), 32'd1);
        chk("t3_wrap_acc", acc_out[0], 32'h1255_000C);

        // Back-pressure
        send(32'h10, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h20; in_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t4_stall_ready", 32'(in_ready[0]), 32'd0);
            chk("t4_stall_acc", acc_out[0], 32'h10);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_result", acc_out[0], 32'h30);
        chk("t4_count", 32'(op_count[0]), 32'd2);
        @(posedge clk); #1;
        chk("t4_no_dup", acc_out[0], 32'h30);
        chk("t4_drained", 32'(out_valid[0]), 32'd0);

        // Streaming 48 operands
        ref_sum = 0; ref_sticky = 1'b0;
        for (int i = 0; i < 48; i++) begin
            d = 32'h9E37_79B9 * 32'(i + 1) + 32'(i);
            ref_sum = ref_sum + {32'd0, d};
            if (ref_sum >= 64'h1_0000_0000) begin
                ref_sticky = 1'b1;
                ref_sum = ref_sum - 64'h1_0000_0000;
            end
            send(d, i == 0);
            chk("t5_stream_valid", 32'(out_valid[0]), 32'd1);
        end
        chk("t5_sum", acc_out[0], ref_sum[31:0]);
        chk("t5_count", 32'(op_count[0]), 32'd48);
        chk("t5_sticky", 32'(sticky[0]), 32'(ref_sticky));

        // Mid-stream reset
        send(32'h77, 1'b1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        chk("t6_rst_valid", 32'(out_valid[0]), 32'd0);
        chk("t6_rst_acc", acc_out[0], 32'h0);
        chk("t6_rst_count", 32'(op_count[0]), 32'd0);
        out_ready = 1'b1;
        send(32'h0011_0110, 1'b0);
        chk("t6_acc", acc_out[0], 32'h0011_0110);
        chk("t6_count", 32'(op_count[0]), 32'd1);

        // Counter saturates at 255
        for (int i = 0; i < 260; i++) send(32'h1, i == 0);
        chk("t7_count_sat", 32'(op_count[0]), 32'd255);
        chk("t7_acc", acc_out[0], 32'd260);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
